// File: rtl/relu_maxpool22_pkg.sv
// Shared definitions for the S4 pooling stage: default widths, map geometry and the
// requantising helper (shift + clamp) also used by other requantising stages.
package relu_maxpool22_pkg;

   localparam int DEF_BIT_WIDTH = 8;
   localparam int DEF_OUT_WIDTH = 32;
   localparam int C3_MAP_SIZE   = 10;
   localparam int POOL_SIZE     = 2;

   // Arithmetic shift, then clamp to the signed range of a bw-bit result.
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x,
                                                    input int unsigned       sh,
                                                    input int unsigned       bw);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = x >>> sh;
      hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bw - 1));
      if (s > hi)
         sat_shift = hi;
      else if (s < lo)
         sat_shift = lo;
      else
         sat_shift = s;
   endfunction

endpackage

// File: rtl/relu_maxpool22_linebuf.sv
// Half-row line buffer for the 2x2 pool: one write port, one asynchronous read port.
// Contents are not reset; every entry is written on an even row before it is read.
module pool_linebuf #(
   parameter int DEPTH = 5,
   parameter int AW    = 3,
   parameter int W     = 32
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i)
         mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/relu_maxpool22.sv
// Streaming 2x2/stride-2 max-pool with rescale and saturation, one sample per valid cycle.
// Optional ReLU on the pooled value when RELU_EN is defined.
module relu_maxpool22
   import relu_maxpool22_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int IN_SIZE   = C3_MAP_SIZE,
   parameter int SHIFT     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic signed [OUT_WIDTH-1:0] in_data,
   output logic                        out_valid,
   output logic signed [BIT_WIDTH-1:0] out_data,
   output logic                        frame_done
);

   localparam int CW   = $clog2(IN_SIZE);
   localparam int AW   = CW - 1;
   localparam int HALF = IN_SIZE / 2;
   localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);

   logic [CW-1:0]               col_q, col_d;
   logic [CW-1:0]               row_q, row_d;
   logic signed [OUT_WIDTH-1:0] pair_q, pair_d;
   logic                        out_valid_q, out_valid_d;
   logic signed [BIT_WIDTH-1:0] out_data_q, out_data_d;
   logic                        frame_done_q, frame_done_d;

   logic signed [OUT_WIDTH-1:0] h, m, m_r, lb_rdata;
   logic                        lb_wr;

   pool_linebuf #(
      .DEPTH (HALF),
      .AW    (AW),
      .W     (OUT_WIDTH)
   ) u_linebuf (
      .clk     (clk),
      .wr_en_i (lb_wr),
      .waddr_i (col_q[CW-1:1]),
      .wdata_i (h),
      .raddr_i (col_q[CW-1:1]),
      .rdata_o (lb_rdata)
   );

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      frame_done_d = 1'b0;
      lb_wr        = 1'b0;
      h = (in_data > pair_q) ? in_data : pair_q;
      m = (lb_rdata > h) ? lb_rdata : h;
`ifdef RELU_EN
      m_r = m[OUT_WIDTH-1] ? '0 : m;
`else
      m_r = m;
`endif
      if (in_valid) begin
         if (col_q == LAST) begin
            col_d = '0;
            row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_q[0]) begin
            pair_d = in_data;
         end else if (!row_q[0]) begin
            lb_wr = 1'b1;
         end else begin
            out_valid_d  = 1'b1;
            out_data_d   = BIT_WIDTH'(sat_shift(64'(m_r), SHIFT, BIT_WIDTH));
            frame_done_d = (row_q == LAST) && (col_q == LAST);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         pair_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool22.sv
// Directed bench for relu_maxpool22: two instances (SHIFT=0 and SHIFT=8) share one stimulus stream.
module tb_relu_maxpool22;

   localparam int BW = 8;
   localparam int OW = 32;
   localparam int N  = 10;
`ifdef RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [OW-1:0] in_data = '0;
   logic                 v0, fd0, v8, fd8;
   logic signed [BW-1:0] d0, d8;

   int checks   = 0;
   int failures = 0;
   int nfd0     = 0;
   logic signed [BW-1:0] q0[$];
   logic signed [BW-1:0] q8[$];
   bit                   f0[$];

   always #5 clk = ~clk;

   relu_maxpool22 #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .IN_SIZE(N), .SHIFT(0)) u_s0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(v0), .out_data(d0), .frame_done(fd0));

   relu_maxpool22 #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .IN_SIZE(N), .SHIFT(8)) u_s8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(v8), .out_data(d8), .frame_done(fd8));

   always @(negedge clk) begin
      if (v0) begin
         q0.push_back(d0);
         f0.push_back(fd0);
      end
      if (v8) q8.push_back(d8);
      if (fd0) nfd0++;
   end

   function automatic int pix(input int kind, input int r, input int c);
      int mn;
      mn = -2147483647 - 1;
      case (kind)
         0: pix = r * 10 + c;
         1: pix = -5;
         2: begin
            if (r < 2 && c < 2)
               pix = (r == 0 && c == 0) ? 40000 : r * 2 + c;
            else if (r < 2 && c < 4)
               pix = -40000;
            else
               pix = 0;
         end
         default: begin
            if (r < 2 && c < 2)
               pix = (r == c) ? 0 : mn;
            else if (r < 2 && c < 4)
               pix = mn;
            else
               pix = 0;
         end
      endcase
   endfunction

   function automatic int ramp_exp(input int i);
      ramp_exp = (2 * ((i % 25) / 5) + 1) * 10 + 2 * (i % 5) + 1;
   endfunction

   task automatic send(input bit v, input int d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) send(1'b0, 0);
   endtask

   task automatic send_frame(input int kind, input bit gaps);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (gaps) repeat ($urandom_range(0, 1)) send(1'b0, int'($urandom));
            send(1'b1, pix(kind, r, c));
         end
   endtask

   task automatic clear_q();
      q0.delete();
      q8.delete();
      f0.delete();
      nfd0 = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (v0 !== 1'b0 || fd0 !== 1'b0 || d0 !== 8'sd0) begin
         failures++;
         $display("FAIL reset_s0 got v=%b fd=%b d=%0d want v=0 fd=0 d=0", v0, fd0, d0);
      end
      checks++;
      if (v8 !== 1'b0 || fd8 !== 1'b0 || d8 !== 8'sd0) begin
         failures++;
         $display("FAIL reset_s8 got v=%b fd=%b d=%0d want v=0 fd=0 d=0", v8, fd8, d8);
      end
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      clear_q();
      send_frame(0, 1'b0);
      idle(3);
      checks++;
      if (q0.size() != 25 || q8.size() != 25 || nfd0 != 1) begin
         failures++;
         $display("FAIL ramp_count got %0d/%0d fd=%0d want 25/25 fd=1", q0.size(), q8.size(), nfd0);
      end
      for (int i = 0; i < q0.size(); i++) begin
         checks++;
         if (int'(q0[i]) != ramp_exp(i) || f0[i] != (i == 24)) begin
            failures++;
            $display("FAIL ramp_s0[%0d] got %0d fd=%b want %0d fd=%b", i, q0[i], f0[i], ramp_exp(i), i == 24);
         end
      end
      for (int i = 0; i < q8.size(); i++) begin
         checks++;
         if (int'(q8[i]) != 0) begin
            failures++;
            $display("FAIL ramp_s8[%0d] got %0d want 0", i, q8[i]);
         end
      end
      checks++;
      if (v0 !== 1'b0 || int'(d0) != 99) begin
         failures++;
         $display("FAIL ramp_hold got v=%b d=%0d want v=0 d=99", v0, d0);
      end
   endtask

   task automatic test_negative();
      int e0, e8;
      e0 = RELU ? 0 : -5;
      e8 = RELU ? 0 : -1;
      clear_q();
      send_frame(1, 1'b0);
      idle(3);
      checks++;
      if (q0.size() != 25 || q8.size() != 25) begin
         failures++;
         $display("FAIL neg_count got %0d/%0d want 25/25", q0.size(), q8.size());
      end
      for (int i = 0; i < q0.size(); i++) begin
         checks++;
         if (int'(q0[i]) != e0 || f0[i] != (i == 24)) begin
            failures++;
            $display("FAIL neg_s0[%0d] got %0d fd=%b want %0d fd=%b", i, q0[i], f0[i], e0, i == 24);
         end
      end
      for (int i = 0; i < q8.size(); i++) begin
         checks++;
         if (int'(q8[i]) != e8) begin
            failures++;
            $display("FAIL neg_s8[%0d] got %0d want %0d", i, q8[i], e8);
         end
      end
   endtask

   task automatic test_saturation();
      int eneg;
      eneg = RELU ? 0 : -128;
      clear_q();
      send_frame(2, 1'b0);
      idle(3);
      checks++;
      if (q0.size() != 25 || q8.size() != 25) begin
         failures++;
         $display("FAIL sat_count got %0d/%0d want 25/25", q0.size(), q8.size());
      end else begin
         checks++;
         if (int'(q8[0]) != 127 || int'(q0[0]) != 127) begin
            failures++;
            $display("FAIL sat_pos got s8=%0d s0=%0d want 127 127", q8[0], q0[0]);
         end
         checks++;
         if (int'(q8[1]) != eneg || int'(q0[1]) != eneg) begin
            failures++;
            $display("FAIL sat_neg got s8=%0d s0=%0d want %0d", q8[1], q0[1], eneg);
         end
         checks++;
         if (int'(q8[2]) != 0 || int'(q0[24]) != 0) begin
            failures++;
            $display("FAIL sat_rest got s8[2]=%0d s0[24]=%0d want 0", q8[2], q0[24]);
         end
      end
   endtask

   task automatic test_gaps();
      clear_q();
      send_frame(0, 1'b1);
      send_frame(0, 1'b1);
      idle(3);
      checks++;
      if (q0.size() != 50 || q8.size() != 50 || nfd0 != 2) begin
         failures++;
         $display("FAIL gaps_count got %0d/%0d fd=%0d want 50/50 fd=2", q0.size(), q8.size(), nfd0);
      end
      for (int i = 0; i < q0.size(); i++) begin
         checks++;
         if (int'(q0[i]) != ramp_exp(i) || f0[i] != ((i % 25) == 24)) begin
            failures++;
            $display("FAIL gaps_s0[%0d] got %0d fd=%b want %0d", i, q0[i], f0[i], ramp_exp(i));
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 37; k++) send(1'b1, k);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (v0 !== 1'b0 || d0 !== 8'sd0) begin
         failures++;
         $display("FAIL midrst_clear got v=%b d=%0d want v=0 d=0", v0, d0);
      end
      clear_q();
      rst = 1'b0;
      send_frame(0, 1'b0);
      idle(3);
      checks++;
      if (q0.size() != 25 || nfd0 != 1) begin
         failures++;
         $display("FAIL midrst_count got %0d fd=%0d want 25 fd=1", q0.size(), nfd0);
      end
      for (int i = 0; i < q0.size(); i++) begin
         checks++;
         if (int'(q0[i]) != ramp_exp(i) || f0[i] != (i == 24)) begin
            failures++;
            $display("FAIL midrst_s0[%0d] got %0d fd=%b want %0d", i, q0[i], f0[i], ramp_exp(i));
         end
      end
   endtask

   task automatic test_min_negative();
      int eneg;
      eneg = RELU ? 0 : -128;
      clear_q();
      send_frame(3, 1'b0);
      idle(3);
      checks++;
      if (q0.size() != 25 || q8.size() != 25) begin
         failures++;
         $display("FAIL minneg_count got %0d/%0d want 25/25", q0.size(), q8.size());
      end else begin
         checks++;
         if (int'(q0[0]) != 0 || int'(q8[0]) != 0) begin
            failures++;
            $display("FAIL minneg_mixed got s0=%0d s8=%0d want 0 0", q0[0], q8[0]);
         end
         checks++;
         if (int'(q0[1]) != eneg || int'(q8[1]) != eneg) begin
            failures++;
            $display("FAIL minneg_all got s0=%0d s8=%0d want %0d", q0[1], q8[1], eneg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_negative();
      test_saturation();
      test_gaps();
      test_reset_mid();
      test_min_negative();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
